// File: rtl/freq_meter_pkg.sv
// Shared constants, BCD FSM state type and the per-digit add-3 helper
// used by the frequency meter and its BCD converter.
package freq_meter_pkg;

  localparam int DEFAULT_GATE_CYCLES = 50_000_000;
  localparam int DEFAULT_CNT_W       = 20;
  localparam int BCD_DIGITS          = 7;
  localparam int BCD_W               = 4 * BCD_DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } bcd_state_e;

  // Double-dabble correction: any digit >= 5 gets +3 before the next shift.
  function automatic logic [BCD_W-1:0] bcd_add3(input logic [BCD_W-1:0] d);
    logic [BCD_W-1:0] r;
    r = d;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (d[4*i +: 4] >= 4'd5) r[4*i +: 4] = d[4*i +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/freq_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-add-3), one bit per cycle.
// Starts on a start_i strobe seen in IDLE; strobes in any other state are dropped.
module freq_bcd_conv
  import freq_meter_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [CNT_W-1:0] bin_i,
  output logic [BCD_W-1:0] bcd_o,
  output logic             bcd_valid_o,
  output bcd_state_e       state_o
);

  localparam int SW = $clog2(CNT_W + 1);
  localparam logic [SW-1:0] SHIFT_LAST = SW'(CNT_W - 1);

  bcd_state_e       state_q;
  logic [CNT_W-1:0] bin_q;
  logic [BCD_W-1:0] scratch_q;
  logic [BCD_W-1:0] scratch_d;
  logic [SW-1:0]    shift_cnt_q;

  always_comb begin
    scratch_d = bcd_add3(scratch_q);
    scratch_d = {scratch_d[BCD_W-2:0], bin_q[CNT_W-1]};
  end

  // bcd_o is written on the final shift so bcd_valid_o is high exactly while in DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      scratch_q   <= '0;
      shift_cnt_q <= '0;
      bcd_o       <= '0;
      bcd_valid_o <= 1'b0;
    end else begin
      bcd_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) state_q <= LOAD;
        end
        LOAD: begin
          bin_q       <= bin_i;
          scratch_q   <= '0;
          shift_cnt_q <= '0;
          state_q     <= SHIFT;
        end
        SHIFT: begin
          scratch_q   <= scratch_d;
          bin_q       <= {bin_q[CNT_W-2:0], 1'b0};
          shift_cnt_q <= shift_cnt_q + 1'b1;
          if (shift_cnt_q == SHIFT_LAST) begin
            bcd_o       <= scratch_d;
            bcd_valid_o <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/freq_meter.sv
// Gated edge-counting frequency meter: counts sigin rises over a fixed window
// of sysclk cycles and reports the count in binary and BCD.
module freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEFAULT_GATE_CYCLES,
  parameter int CNT_W       = DEFAULT_CNT_W
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             sigin,
  output logic [CNT_W-1:0] freq,
  output logic             freq_valid,
  output logic             overflow,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output bcd_state_e       bcd_state_o
);

  // freq_valid and bcd_valid are single-cycle strobes with no ready: a consumer
  // captures the value on the strobe; freq/overflow/bcd then hold until the next one.
  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic             sync1_q, sync2_q, prev_q, edge_q;
  logic [GW-1:0]    gate_q, gate_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] freq_q;
  logic             freq_valid_q, overflow_q;
  logic             terminal, at_max;

  always_comb begin
    terminal = (gate_q == GATE_LAST);
    at_max   = (cnt_q == CNT_MAX);
    gate_d   = terminal ? '0 : gate_q + 1'b1;
    cnt_d    = (edge_q && !at_max) ? cnt_q + 1'b1 : cnt_q;
    sticky_d = sticky_q | (edge_q & at_max);
  end

  // The terminal cycle publishes cnt_d so an edge landing there closes with this window.
  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      prev_q       <= 1'b0;
      edge_q       <= 1'b0;
      gate_q       <= '0;
      cnt_q        <= '0;
      sticky_q     <= 1'b0;
      freq_q       <= '0;
      freq_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      sync1_q      <= sigin;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      edge_q       <= sync2_q & ~prev_q;
      gate_q       <= gate_d;
      freq_valid_q <= terminal;
      if (terminal) begin
        freq_q     <= cnt_d;
        overflow_q <= sticky_d;
        cnt_q      <= '0;
        sticky_q   <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        sticky_q <= sticky_d;
      end
    end
  end

  assign freq       = freq_q;
  assign freq_valid = freq_valid_q;
  assign overflow   = overflow_q;

  freq_bcd_conv #(.CNT_W(CNT_W)) u_bcd (
    .clk_i       (sysclk),
    .rst_i       (rst),
    .start_i     (freq_valid_q),
    .bin_i       (freq_q),
    .bcd_o       (bcd),
    .bcd_valid_o (bcd_valid),
    .state_o     (bcd_state_o)
  );

endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: two instances (wide counter, and a 4-bit counter that
// saturates) share clock and reset; window results are predicted from sigin timing.
module tb_freq_meter;
  import freq_meter_pkg::*;

  localparam int GA = 400;
  localparam int WA = 20;
  localparam int GB = 200;
  localparam int WB = 4;
  localparam int MAXA = (1 << WA) - 1;
  localparam int MAXB = (1 << WB) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic             sig_a = 1'b0, sig_b = 1'b0;
  logic [WA-1:0]    freq_a;
  logic [WB-1:0]    freq_b;
  logic             fv_a, fv_b, ovf_a, ovf_b, bv_a, bv_b;
  logic [BCD_W-1:0] bcd_a, bcd_b;
  bcd_state_e       st_a, st_b;

  freq_meter #(.GATE_CYCLES(GA), .CNT_W(WA)) dut_a (
    .sysclk(clk), .rst(rst), .sigin(sig_a), .freq(freq_a), .freq_valid(fv_a),
    .overflow(ovf_a), .bcd(bcd_a), .bcd_valid(bv_a), .bcd_state_o(st_a)
  );

  freq_meter #(.GATE_CYCLES(GB), .CNT_W(WB)) dut_b (
    .sysclk(clk), .rst(rst), .sigin(sig_b), .freq(freq_b), .freq_valid(fv_b),
    .overflow(ovf_b), .bcd(bcd_b), .bcd_valid(bv_b), .bcd_state_o(st_b)
  );

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int n = 0;  // posedges since reset release
  int mode_a = 0, per_a = 40, t1_a = -10, t2_a = -10;
  int mode_b = 0, per_b = 8;
  bit prev_a = 1'b0, prev_b = 1'b0;
  int cnt_a[0:127];
  int cnt_b[0:127];
  int nw_a = 1, nw_b = 1;
  int fv_n_a = 0, fv_n_b = 0;
  logic [WA-1:0] last_a = '0;
  logic [WB-1:0] last_b = '0;

  logic [WA:0]      exp_a_q[$];
  logic [WB:0]      exp_b_q[$];
  logic [BCD_W-1:0] bcd_a_q[$];
  logic [BCD_W-1:0] bcd_b_q[$];
  logic [WA:0]      ea;
  logic [WB:0]      eb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [BCD_W-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit level(input int mode, input int per, input int t1, input int t2,
                               input int cyc);
    case (mode)
      1:       return 1'b1;
      2:       return (cyc % per) < (per / 2);
      3:       return (cyc == t1) || (cyc == t1 + 1) || (cyc == t2) || (cyc == t2 + 1);
      default: return 1'b0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // A rise driven after edge c is counted at edge c+4; windows close on edges k*G.
  task automatic step();
    bit lv;
    int c;
    @(posedge clk);
    n++;
    #1;
    lv = level(mode_a, per_a, t1_a, t2_a, n);
    sig_a = lv;
    if (lv && !prev_a) cnt_a[(n + 3 + GA) / GA]++;
    prev_a = lv;
    lv = level(mode_b, per_b, 0, 0, n);
    sig_b = lv;
    if (lv && !prev_b) cnt_b[(n + 3 + GB) / GB]++;
    prev_b = lv;
    if (n == GA * nw_a - 4) begin
      c = cnt_a[nw_a];
      exp_a_q.push_back({c > MAXA, (c > MAXA) ? WA'(MAXA) : WA'(c)});
      nw_a++;
    end
    if (n == GB * nw_b - 4) begin
      c = cnt_b[nw_b];
      exp_b_q.push_back({c > MAXB, (c > MAXB) ? WB'(MAXB) : WB'(c)});
      nw_b++;
    end
  endtask

  task automatic run_to(input int target);
    while (n < target) step();
  endtask

  task automatic check_zero(input string ctx);
    check({ctx, "_freq_a"}, freq_a, 0);
    check({ctx, "_fv_a"}, fv_a, 0);
    check({ctx, "_ovf_a"}, ovf_a, 0);
    check({ctx, "_bcd_a"}, bcd_a, 0);
    check({ctx, "_bv_a"}, bv_a, 0);
    check({ctx, "_state_a"}, 32'(st_a), 32'(IDLE));
    check({ctx, "_freq_b"}, freq_b, 0);
    check({ctx, "_fv_b"}, fv_b, 0);
    check({ctx, "_ovf_b"}, ovf_b, 0);
    check({ctx, "_bcd_b"}, bcd_b, 0);
    check({ctx, "_bv_b"}, bv_b, 0);
    check({ctx, "_state_b"}, 32'(st_b), 32'(IDLE));
  endtask

  // Asserts reset between clock edges, checks the asynchronous clear, then releases.
  task automatic do_reset(input string ctx);
    rst = 1'b1;
    sig_a = 1'b0;
    sig_b = 1'b0;
    #2;
    check_zero(ctx);
    repeat (2) @(posedge clk);
    #1;
    exp_a_q.delete();
    exp_b_q.delete();
    bcd_a_q.delete();
    bcd_b_q.delete();
    for (int i = 0; i < 128; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    nw_a = 1; nw_b = 1;
    prev_a = 1'b0; prev_b = 1'b0;
    mode_a = 0; mode_b = 0;
    t1_a = -10; t2_a = -10;
    last_a = '0; last_b = '0;
    n = 0;
    rst = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (fv_a) begin
        if (exp_a_q.size() == 0) check("a_fv_spurious", fv_a, 0);
        else begin
          ea = exp_a_q.pop_front();
          check("a_freq", freq_a, ea[WA-1:0]);
          check("a_ovf", ovf_a, ea[WA]);
          check("a_fv_cycle", n % GA, 0);
          bcd_a_q.push_back(to_bcd(int'(ea[WA-1:0])));
          last_a = ea[WA-1:0];
          fv_n_a = n;
        end
      end else if (n % GA == GA / 2) begin
        check("a_freq_hold", freq_a, last_a);
      end
      if (bv_a) begin
        if (bcd_a_q.size() == 0) check("a_bv_spurious", bv_a, 0);
        else begin
          check("a_bcd", bcd_a, bcd_a_q.pop_front());
          check("a_bcd_lag", n - fv_n_a, WA + 2);
        end
      end
      if (fv_b) begin
        if (exp_b_q.size() == 0) check("b_fv_spurious", fv_b, 0);
        else begin
          eb = exp_b_q.pop_front();
          check("b_freq", freq_b, eb[WB-1:0]);
          check("b_ovf", ovf_b, eb[WB]);
          check("b_fv_cycle", n % GB, 0);
          bcd_b_q.push_back(to_bcd(int'(eb[WB-1:0])));
          last_b = eb[WB-1:0];
          fv_n_b = n;
        end
      end else if (n % GB == GB / 2) begin
        check("b_freq_hold", freq_b, last_b);
      end
      if (bv_b) begin
        if (bcd_b_q.size() == 0) check("b_bv_spurious", bv_b, 0);
        else begin
          check("b_bcd", bcd_b, bcd_b_q.pop_front());
          check("b_bcd_lag", n - fv_n_b, WB + 2);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 128; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    repeat (2) @(posedge clk);
    do_reset("init");

    // Steady periodic input: A sees 10 per window, B saturates at 15.
    mode_a = 2; per_a = 40;
    mode_b = 2; per_b = 8;
    run_to(3 * GA);

    // Random period for A (count varies with phase); B held low reports 0.
    mode_a = 2; per_a = $urandom_range(30, 90);
    mode_b = 0;
    run_to(6 * GA);

    // A: one edge lands in the terminal cycle of window 8, another just after window 9.
    mode_a = 3; t1_a = 8 * GA - 4; t2_a = 9 * GA - 3;
    mode_b = 1;
    run_to(10 * GA);

    // Reset while A's converter is shifting.
    mode_a = 2; per_a = 40;
    mode_b = 2; per_b = 8;
    run_to(10 * GA + 5);
    do_reset("rst_shift");

    // Reset mid-window.
    mode_a = 2; per_a = 50;
    run_to(150);
    do_reset("rst_midwin");

    mode_a = 2; per_a = 40;
    mode_b = 2; per_b = 8;
    run_to(2 * GA + 30);

    check("a_exp_drain", exp_a_q.size(), 0);
    check("b_exp_drain", exp_b_q.size(), 0);
    check("a_bcd_drain", bcd_a_q.size(), 0);
    check("b_bcd_drain", bcd_b_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
